// File: rtl/memarb_pkg.sv
// Shared types and helpers for the RISC5 memory arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: state_e FSM encoding, IO_BASE_HI window tag, be_decode() byte-lane helper.
package memarb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      GAP   = 2'd2
   } state_e;

   // cpu_adr[23:6] equal to this selects the 64-byte I/O window at the top of the map.
   localparam logic [17:0] IO_BASE_HI = 18'h3FFFF;

   // Word access drives all lanes; byte access drives only the addressed lane.
   function automatic logic [3:0] be_decode(input logic ben, input logic [1:0] adr);
      logic [3:0] be;
      be = ben ? (4'b0001 << adr) : 4'b1111;
      return be;
   endfunction

endpackage

// File: rtl/memarb_burst_seq.sv
// DMA burst sequencer: IDLE/BURST/GAP FSM, burst word pointer, burst and gap counters.
// Latency: grant on the edge that sees dma_req in IDLE; BURST_LEN words on the following cycles.
// Backpressure: none on the DMA side; the core is held off via the registered cpu_stall.
// Ports: clk, rst (sync, active-high), dma_req/dma_adr in; burst_active, cpu_stall, dma_valid,
//        dma_ack, ptr out; steal_cnt out only when MEMARB_STATS_EN is defined.
module memarb_burst_seq
   import memarb_pkg::*;
#(
   parameter int AW        = 22,
   parameter int BURST_LEN = 8,
   parameter int MIN_GAP   = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          dma_req,
   input  logic [AW-1:0] dma_adr,
   output logic          burst_active,
   output logic          cpu_stall,
   output logic          dma_valid,
   output logic          dma_ack,
   output logic [AW-1:0] ptr
`ifdef MEMARB_STATS_EN
   ,
   output logic [31:0]   steal_cnt
`endif
);

   localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(BURST_LEN - 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

   state_e        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [GW-1:0] gap;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (dma_req) state_nxt = BURST;
         BURST:   if (cnt == '0) state_nxt = (MIN_GAP > 0) ? GAP : IDLE;
         GAP:     if (gap == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cpu_stall <= 1'b0;
         ptr       <= '0;
         cnt       <= '0;
         gap       <= '0;
      end else begin
         state     <= state_nxt;
         // Stall comes from a flop so it never follows the core's gated strobes.
         cpu_stall <= (state_nxt == BURST);
         unique case (state)
            IDLE: begin
               if (dma_req) begin
                  ptr <= dma_adr;
                  cnt <= CNT_LOAD;
               end
            end
            BURST: begin
               ptr <= ptr + AW'(1);
               cnt <= cnt - CW'(1);
               if (cnt == '0) gap <= GAP_LOAD;
            end
            GAP: gap <= gap - GW'(1);
            default: ;
         endcase
      end
   end

   assign burst_active = (state == BURST);
   assign dma_valid    = burst_active;
   assign dma_ack      = burst_active && (cnt == '0);

`ifdef MEMARB_STATS_EN
   // Counts stolen cycles; sticks at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst)
         steal_cnt <= '0;
      else if (burst_active && (steal_cnt != '1))
         steal_cnt <= steal_cnt + 32'd1;
   end
`endif

endmodule

// File: rtl/risc5_mem_arbiter.sv
// Muxes the RISC5 core port onto an async SRAM and a 64-byte I/O window; steals cycles for DMA bursts.
// Latency: core accesses are single-cycle combinational; a DMA burst costs the core BURST_LEN cycles.
// Backpressure: registered cpu_stall is high exactly during BURST; DMA has no backpressure.
// Ports: clk, rst; core side cpu_adr/rd/wr/ben/wdata in, cpu_rdata/code/stall out; io_rd/wr/adr out,
//        io_rdata in; dma_req/adr in, dma_valid/data/ack out; sram_adr/we/be/wdata out, sram_rdata in.
//        Optional steal_cnt out when MEMARB_STATS_EN is defined.
module risc5_mem_arbiter
   import memarb_pkg::*;
#(
   parameter int AW        = 22,
   parameter int BURST_LEN = 8,
   parameter int MIN_GAP   = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [23:0]   cpu_adr,
   input  logic          cpu_rd,
   input  logic          cpu_wr,
   input  logic          cpu_ben,
   input  logic [31:0]   cpu_wdata,
   output logic [31:0]   cpu_rdata,
   output logic [31:0]   cpu_code,
   output logic          cpu_stall,
   output logic          io_rd,
   output logic          io_wr,
   output logic [3:0]    io_adr,
   input  logic [31:0]   io_rdata,
   input  logic          dma_req,
   input  logic [AW-1:0] dma_adr,
   output logic          dma_valid,
   output logic [31:0]   dma_data,
   output logic          dma_ack,
   output logic [AW-1:0] sram_adr,
   output logic          sram_we,
   output logic [3:0]    sram_be,
   output logic [31:0]   sram_wdata,
   input  logic [31:0]   sram_rdata
`ifdef MEMARB_STATS_EN
   ,
   output logic [31:0]   steal_cnt
`endif
);

   logic          burst_active;
   logic [AW-1:0] ptr;
   logic          io_sel;
   logic          core_own;

   memarb_burst_seq #(
      .AW        (AW),
      .BURST_LEN (BURST_LEN),
      .MIN_GAP   (MIN_GAP)
   ) u_seq (
      .clk          (clk),
      .rst          (rst),
      .dma_req      (dma_req),
      .dma_adr      (dma_adr),
      .burst_active (burst_active),
      .cpu_stall    (cpu_stall),
      .dma_valid    (dma_valid),
      .dma_ack      (dma_ack),
      .ptr          (ptr)
`ifdef MEMARB_STATS_EN
      ,
      .steal_cnt    (steal_cnt)
`endif
   );

   assign core_own   = ~burst_active;
   assign io_sel     = (cpu_adr[23:6] == IO_BASE_HI);

   assign sram_adr   = burst_active ? ptr : cpu_adr[AW+1:2];
   // Strobes are masked during a burst even though the stalled core should already hold them low.
   assign sram_we    = core_own & cpu_wr & ~io_sel;
   assign sram_be    = burst_active ? 4'b1111 : be_decode(cpu_ben, cpu_adr[1:0]);
   assign sram_wdata = cpu_wdata;

   assign io_rd      = core_own & cpu_rd & io_sel;
   assign io_wr      = core_own & cpu_wr & io_sel;
   assign io_adr     = cpu_adr[5:2];

   assign cpu_rdata  = io_sel ? io_rdata : sram_rdata;
   assign cpu_code   = sram_rdata;
   assign dma_data   = sram_rdata;

endmodule

// File: tb/tb_risc5_mem_arbiter.sv
// Directed bench for risc5_mem_arbiter (AW=22, BURST_LEN=8, MIN_GAP=2).
// SRAM model returns {10'h2A5, address}; writes are captured at the clock edge.
// Inputs change after the rising edge; outputs are sampled at the falling edge.
module tb_risc5_mem_arbiter;

   localparam int AW = 22;

   logic          clk = 1'b0;
   logic          rst;
   logic [23:0]   cpu_adr;
   logic          cpu_rd, cpu_wr, cpu_ben;
   logic [31:0]   cpu_wdata, cpu_rdata, cpu_code;
   logic          cpu_stall;
   logic          io_rd, io_wr;
   logic [3:0]    io_adr;
   logic [31:0]   io_rdata;
   logic          dma_req;
   logic [AW-1:0] dma_adr;
   logic          dma_valid, dma_ack;
   logic [31:0]   dma_data;
   logic [AW-1:0] sram_adr;
   logic          sram_we;
   logic [3:0]    sram_be;
   logic [31:0]   sram_wdata, sram_rdata;
`ifdef MEMARB_STATS_EN
   logic [31:0]   steal_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;
   int            wr_count = 0;
   logic [AW-1:0] last_wr_adr;
   logic [31:0]   last_wr_data;
   logic [3:0]    last_wr_be;

   always #5 clk = ~clk;

   assign sram_rdata = {10'h2A5, sram_adr};
   assign io_rdata   = 32'h10C0_FFEE;

   always @(posedge clk) begin
      if (sram_we === 1'b1) begin
         wr_count     <= wr_count + 1;
         last_wr_adr  <= sram_adr;
         last_wr_data <= sram_wdata;
         last_wr_be   <= sram_be;
      end
   end

   risc5_mem_arbiter #(.AW(AW), .BURST_LEN(8), .MIN_GAP(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_adr    (cpu_adr),
      .cpu_rd     (cpu_rd),
      .cpu_wr     (cpu_wr),
      .cpu_ben    (cpu_ben),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_code   (cpu_code),
      .cpu_stall  (cpu_stall),
      .io_rd      (io_rd),
      .io_wr      (io_wr),
      .io_adr     (io_adr),
      .io_rdata   (io_rdata),
      .dma_req    (dma_req),
      .dma_adr    (dma_adr),
      .dma_valid  (dma_valid),
      .dma_data   (dma_data),
      .dma_ack    (dma_ack),
      .sram_adr   (sram_adr),
      .sram_we    (sram_we),
      .sram_be    (sram_be),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
`ifdef MEMARB_STATS_EN
      ,
      .steal_cnt  (steal_cnt)
`endif
   );

   function automatic logic [31:0] pat(input logic [AW-1:0] a);
      return {10'h2A5, a};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // One burst cycle: word i of a burst starting at start.
   task automatic burst_cycle(input string tag, input logic [AW-1:0] start, input int i);
      logic [AW-1:0] a;
      a = start + AW'(i);
      check({tag, " stall"}, 64'(cpu_stall), 64'(1));
      check({tag, " valid"}, 64'(dma_valid), 64'(1));
      check({tag, " adr"},   64'(sram_adr),  64'(a));
      check({tag, " data"},  64'(dma_data),  64'(pat(a)));
      check({tag, " ack"},   64'(dma_ack),   64'(i == 7));
      check({tag, " we"},    64'(sram_we),   64'(0));
      check({tag, " iowr"},  64'(io_wr),     64'(0));
   endtask

   task automatic quiet_cycle(input string tag);
      check({tag, " stall"}, 64'(cpu_stall), 64'(0));
      check({tag, " valid"}, 64'(dma_valid), 64'(0));
      check({tag, " ack"},   64'(dma_ack),   64'(0));
   endtask

   initial begin
      rst = 1'b1; cpu_adr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_ben = 1'b0;
      cpu_wdata = '0; dma_req = 1'b1; dma_adr = 22'h100;

      // Reset held 3 cycles with dma_req asserted.
      for (int i = 0; i < 3; i++) begin
         step(); settle();
         quiet_cycle("reset");
      end
      rst = 1'b0;

      // First edge after reset release grants; dma_req dropped mid-burst.
      for (int i = 0; i < 8; i++) begin
         step(); settle();
         burst_cycle("b1", 22'h100, i);
         if (i == 0) dma_req = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
         step(); settle();
         quiet_cycle("b1 gap");
`ifdef MEMARB_STATS_EN
         if (i == 0) check("steal after burst", 64'(steal_cnt), 64'(8));
`endif
      end
      step(); settle();
      quiet_cycle("b1 idle");

      // Core byte store to byte 3 of word 4.
      cpu_wr = 1'b1; cpu_ben = 1'b1; cpu_adr = 24'h000013; cpu_wdata = 32'hAB00_0000;
      #1;
      check("bst we",    64'(sram_we),    64'(1));
      check("bst be",    64'(sram_be),    64'(4'b1000));
      check("bst adr",   64'(sram_adr),   64'(22'h4));
      check("bst wdata", 64'(sram_wdata), 64'(32'hAB00_0000));
      check("bst iowr",  64'(io_wr),      64'(0));
      step();
      check("bst count", 64'(wr_count),    64'(1));
      check("bst wadr",  64'(last_wr_adr), 64'(22'h4));
      check("bst wbe",   64'(last_wr_be),  64'(4'b1000));

      // I/O store to register 1.
      cpu_adr = 24'hFFFFC4; cpu_ben = 1'b0;
      settle();
      check("io wr",    64'(io_wr),   64'(1));
      check("io adr",   64'(io_adr),  64'(1));
      check("io sramwe",64'(sram_we), 64'(0));
      check("io rd0",   64'(io_rd),   64'(0));
      step();
      check("io nowr",  64'(wr_count), 64'(1));

      // I/O load.
      cpu_wr = 1'b0; cpu_rd = 1'b1;
      settle();
      check("io rd",    64'(io_rd),     64'(1));
      check("io rdata", 64'(cpu_rdata), 64'(32'h10C0_FFEE));
      step();

      // SRAM word load and fetch.
      cpu_adr = 24'h000040;
      settle();
      check("ld iord",  64'(io_rd),     64'(0));
      check("ld rdata", 64'(cpu_rdata), 64'(pat(22'h10)));
      check("ld code",  64'(cpu_code),  64'(pat(22'h10)));
      check("ld be",    64'(sram_be),   64'(4'b1111));
      step();

      // Byte lane 1.
      cpu_adr = 24'h000041; cpu_ben = 1'b1;
      settle();
      check("ld1 be",   64'(sram_be), 64'(4'b0010));
      step();
      cpu_rd = 1'b0; cpu_ben = 1'b0;

      // Store in the same cycle dma_req rises; burst wraps the address space.
      dma_req = 1'b1; dma_adr = 22'h3FFFFE;
      cpu_wr = 1'b1; cpu_adr = 24'h000020; cpu_wdata = 32'hDEAD_BEEF;
      settle();
      check("cf stall", 64'(cpu_stall), 64'(0));
      check("cf we",    64'(sram_we),   64'(1));
      check("cf adr",   64'(sram_adr),  64'(22'h8));
      for (int i = 0; i < 8; i++) begin
         step(); settle();
         if (i == 0) begin
            check("cf count", 64'(wr_count),     64'(2));
            check("cf wadr",  64'(last_wr_adr),  64'(22'h8));
            check("cf wdata", 64'(last_wr_data), 64'(32'hDEAD_BEEF));
         end
         burst_cycle("b2", 22'h3FFFFE, i);
         if (i == 7) begin
            cpu_wr  = 1'b0;
            dma_adr = 22'h200;
         end
      end
      check("b2 nowr", 64'(wr_count), 64'(2));

      // dma_req held: two GAP cycles, one IDLE cycle, then the next grant.
      for (int i = 0; i < 3; i++) begin
         step(); settle();
         quiet_cycle("b2 gap");
      end

      // Reset during the 4th burst cycle aborts without an ack.
      for (int i = 0; i < 4; i++) begin
         step(); settle();
         burst_cycle("b3", 22'h200, i);
      end
      rst = 1'b1; dma_req = 1'b0;
      step(); settle();
      quiet_cycle("abort");
`ifdef MEMARB_STATS_EN
      check("steal after rst", 64'(steal_cnt), 64'(0));
`endif
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(); settle();
         quiet_cycle("post abort");
      end

      // A fresh full burst after the abort.
      dma_req = 1'b1; dma_adr = 22'h5;
      for (int i = 0; i < 8; i++) begin
         step(); settle();
         burst_cycle("b4", 22'h5, i);
         if (i == 0) dma_req = 1'b0;
      end
      step(); settle();
      quiet_cycle("b4 gap");
`ifdef MEMARB_STATS_EN
      check("steal b4", 64'(steal_cnt), 64'(8));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
